// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative shift-add multiply / restoring divide with pipeline stall
`timescale 1ns/1ps
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       MOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      count;
    logic [2*WIDTH:0]   acc, acc_nxt;
    logic [WIDTH-1:0]   b;
    logic               is_div, neg_q, neg_r;
    logic               load, last, sgn;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     sum, shifted;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, r1_fin, r2_fin;

    assign last = count == CW'(WIDTH-1);
    assign Busy = load | (state == COMPUTE);
    assign Done = state == DONE;

    // state register; reset discards any in-flight operation
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state; a start is accepted from IDLE or straight out of DONE
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE:    begin state_nxt = Start ? COMPUTE : IDLE; load = Start; end
            COMPUTE: state_nxt = last ? DONE : COMPUTE;
            DONE:    begin state_nxt = Start ? COMPUTE : IDLE; load = Start; end
            default: state_nxt = IDLE;
        endcase
    end

    // operand magnitudes, one iteration step, and sign-fixed final results
    always_comb begin
        sgn     = MOp[0];
        abs1    = (sgn & Operand1[WIDTH-1]) ? -Operand1 : Operand1;
        abs2    = (sgn & Operand2[WIDTH-1]) ? -Operand2 : Operand2;
        sum     = acc[2*WIDTH:WIDTH] + {1'b0, b};
        shifted = acc[2*WIDTH-1:WIDTH-1];
        diff    = {1'b0, shifted} - {2'b00, b};
        acc_nxt = is_div ? (diff[WIDTH+1] ? {shifted, acc[WIDTH-2:0], 1'b0}
                                          : {diff[WIDTH:0], acc[WIDTH-2:0], 1'b1})
                         : {1'b0, acc[0] ? sum : acc[2*WIDTH:WIDTH], acc[WIDTH-1:1]};
        prod    = neg_q ? -acc_nxt[2*WIDTH-1:0] : acc_nxt[2*WIDTH-1:0];
        quo     = acc_nxt[WIDTH-1:0];
        rem     = acc_nxt[2*WIDTH-1:WIDTH];
        r1_fin  = is_div ? ((b == '0) ? '1 : (neg_q ? -quo : quo)) : prod[WIDTH-1:0];
        r2_fin  = is_div ? (neg_r ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
    end

    // operand latch, iteration datapath, result registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            acc     <= '0;
            b       <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            count   <= '0;
            Result1 <= '0;
            Result2 <= '0;
        end else if (load) begin
            acc    <= {{(WIDTH+1){1'b0}}, MOp[1] ? abs1 : abs2};
            b      <= MOp[1] ? abs2 : abs1;
            is_div <= MOp[1];
            neg_q  <= sgn & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
            neg_r  <= sgn & Operand1[WIDTH-1];
            count  <= '0;
        end else if (state == COMPUTE) begin
            acc   <= acc_nxt;
            count <= count + 1'b1;
            if (last) begin
                Result1 <= r1_fin;
                Result2 <= r2_fin;
            end
        end
    end
endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: randomized and directed checks of mcycle_unit against an arithmetic model
`timescale 1ns/1ps
module tb_mcycle_unit;
    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  MOp = 2'b00;
    logic [31:0] Operand1 = '0, Operand2 = '0;
    logic [31:0] Result1, Result2;
    logic        Busy, Done;

    int          n_checks = 0, n_fail = 0, n_issued = 0, done_cnt = 0;
    logic [31:0] exp_r1 = '0, exp_r2 = '0, prev_r1 = '0, prev_r2 = '0;

    mcycle_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .MOp(MOp),
        .Operand1(Operand1), .Operand2(Operand2),
        .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    // count every Done pulse independently of the checking flow
    always @(negedge CLK) if (Done) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // returns {Result2, Result1}
    function automatic logic [63:0] model(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (m)
            2'd0: return {32'b0, a} * {32'b0, b};
            2'd1: return 64'(sa * sb);
            2'd2: return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(ia % ib), 32'(ia / ib)};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(20));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        e = model(m, a, b);
        exp_r1 = e[31:0];
        exp_r2 = e[63:32];
        MOp = m;
        Operand1 = a;
        Operand2 = b;
        Start = 1'b1;
        n_issued++;
        #1 check("busy_on_start", 64'(Busy), 64'd1);
    endtask

    task automatic finish_op(input bit noise);
        int cyc;
        bit busy_ok, held_ok;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK);
            cyc = i;
            if (Done) break;
            if (!Busy) busy_ok = 1'b0;
            if (Result1 !== prev_r1 || Result2 !== prev_r2) held_ok = 1'b0;
            Start = noise ? 1'($urandom) : 1'b0;
            MOp = 2'($urandom);
            Operand1 = $urandom;
            Operand2 = $urandom;
        end
        check("done_latency", 64'(cyc), 64'd33);
        check("busy_compute", 64'(busy_ok), 64'd1);
        check("results_held", 64'(held_ok), 64'd1);
        check("result1", 64'(Result1), 64'(exp_r1));
        check("result2", 64'(Result2), 64'(exp_r2));
        prev_r1 = exp_r1;
        prev_r2 = exp_r2;
        Start = 1'b0;
        #1 check("busy_done_nostart", 64'(Busy), 64'd0);
    endtask

    task automatic idle_check();
        @(negedge CLK);
        check("done_one_cycle", 64'(Done), 64'd0);
        check("busy_idle", 64'(Busy), 64'd0);
    endtask

    initial begin
        int d0;
        repeat (2) @(negedge CLK);
        check("rst_result1", 64'(Result1), 64'd0);
        check("rst_result2", 64'(Result2), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        Reset = 1'b1;
        @(negedge CLK);

        issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF); finish_op(1'b0); idle_check();
        check("umul_max_hi", 64'(prev_r2), 64'hFFFFFFFE);
        issue(2'd1, -32'sd3, 32'd7);             finish_op(1'b1); idle_check();
        issue(2'd2, 32'd100, 32'd7);             finish_op(1'b1); idle_check();
        issue(2'd3, -32'sd7, 32'd2);             finish_op(1'b0); idle_check();
        issue(2'd3, 32'h80000000, 32'hFFFFFFFF); finish_op(1'b1); idle_check();
        issue(2'd2, 32'd5, 32'd0);               finish_op(1'b0); idle_check();
        issue(2'd3, -32'sd5, 32'd0);             finish_op(1'b1);
        issue(2'd0, 32'd3, 32'd4);               finish_op(1'b1); idle_check();

        issue(2'($urandom), pick(), pick());
        for (int i = 0; i < 40; i++) begin
            finish_op(1'($urandom));
            if (i == 39) idle_check();
            else begin
                if ($urandom_range(1) == 1) idle_check();
                issue(2'($urandom), pick(), pick());
            end
        end
        check("done_count", 64'(done_cnt), 64'(n_issued));

        issue(2'd0, $urandom, $urandom);
        @(negedge CLK);
        Start = 1'b0;
        repeat (10) @(negedge CLK);
        #2 Reset = 1'b0;
        n_issued--;
        #1;
        check("async_rst_busy", 64'(Busy), 64'd0);
        check("async_rst_done", 64'(Done), 64'd0);
        check("async_rst_r1", 64'(Result1), 64'd0);
        check("async_rst_r2", 64'(Result2), 64'd0);
        @(negedge CLK);
        Reset = 1'b1;
        prev_r1 = '0;
        prev_r2 = '0;
        d0 = done_cnt;
        repeat (40) @(negedge CLK);
        check("no_done_after_rst", 64'(done_cnt), 64'(d0));
        check("idle_after_rst", 64'(Busy), 64'd0);
        issue(2'd1, pick(), pick()); finish_op(1'b0); idle_check();
        check("done_count_final", 64'(done_cnt), 64'(n_issued));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Iterative multi-cycle multiply/divide unit in the execute stage.
- Directly downstream of the condition unit: its start input is the condition-qualified multiply/divide start strobe.
- Latches two operands, runs a WIDTH-step shift-add multiply or restoring divide, and returns two result words.
- Asserts Busy so the pipeline stalls until results are ready.

Parameters:
- WIDTH, 32, operand and result-word width in bits (≥4).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset (Reset=0 resets immediately, independent of CLK).
- Start  input  1  condition-qualified operation start (MStart).
- MOp  input  2  operation: 00 UMUL, 01 SMUL, 10 UDIV, 11 SDIV.
- Operand1  input  WIDTH  multiplicand / dividend.
- Operand2  input  WIDTH  multiplier / divisor.
- Result1  output  WIDTH  product low word / quotient.
- Result2  output  WIDTH  product high word / remainder.
- Busy  output  1  stall request (combinational, see below).
- Done  output  1  one-cycle pulse: results valid this cycle.

Behaviour:
- Reset (Reset=0), at any time including mid-operation:
  - state=IDLE, counter=0, Result1=Result2=0, Done=0, internal operand/accumulator registers=0.
  - Any in-flight operation is discarded; the first operation after reset release needs a fresh Start.
- States: IDLE, COMPUTE, DONE.
  - IDLE: Start=1 → latch Operand1, Operand2, MOp; counter=0; go to COMPUTE. Start=0 → stay.
  - COMPUTE: one iteration per cycle; after iteration WIDTH-1 (counter==WIDTH-1) go to DONE. Start is ignored.
  - DONE: Done=1 for exactly this cycle. Start=1 → latch new operands, go to COMPUTE (back-to-back). Start=0 → go to IDLE.
- Busy = (IDLE & Start) | COMPUTE | (DONE & Start). Busy is combinational so the pipeline stalls in the same cycle Start is raised.
- Latency: Start accepted at edge T; COMPUTE spans the WIDTH cycles after T; DONE occupies cycle T+WIDTH+1. Busy is high from the Start cycle through the last COMPUTE cycle.
- Result1/Result2 registered on the COMPUTE→DONE edge; held stable until the next operation completes or reset. Never updated during COMPUTE.
- Signed operations:
  - Operate on magnitudes (two's-complement absolute values), sign-fixed when results are registered.
  - SMUL: negate the 2·WIDTH-bit product if operand signs differ.
  - SDIV: quotient negative if signs differ; remainder takes the dividend's sign.
- Multiply: per step, if the multiplier LSB=1, add the multiplicand into the upper half of a 2·WIDTH+1 accumulator, then shift right 1. Full 2·WIDTH product; no overflow.
- Divide: restoring, one quotient bit per step, MSB first. Remainder register WIDTH+1 bits wide to hold the subtract borrow.
- Divide by zero (Operand2=0):
  - UDIV: Result1 = all ones, Result2 = Operand1.
  - SDIV: Result1 = all ones (−1), Result2 = Operand1.
  - Full latency is still taken.
- SDIV overflow (Operand1 = most-negative value, Operand2 = −1): Result1 = most-negative value, Result2 = 0.
- MOp or operand changes while COMPUTE is active have no effect; only latched values are used.

Test Plan (WIDTH=32):
- UMUL 0xFFFFFFFF×0xFFFFFFFF, Start held 1 cycle → Busy high 33 cycles (Start cycle + 32 COMPUTE); Done pulse at T+33 with Result2=0xFFFFFFFE, Result1=0x00000001.
- SMUL −3×7 → Result2=0xFFFFFFFF, Result1=0xFFFFFFEB. Then UDIV 100/7 → Result1=14, Result2=2.
- SDIV −7/2 → Result1=0xFFFFFFFD, Result2=0xFFFFFFFF. SDIV 0x80000000/0xFFFFFFFF → Result1=0x80000000, Result2=0.
- UDIV 5/0 → Result1=0xFFFFFFFF, Result2=5 after full latency. SDIV −5/0 → Result1=0xFFFFFFFF, Result2=0xFFFFFFFB.
- Start asserted in DONE cycle with UMUL 3×4 → no IDLE cycle; Busy stays high; previous results held until second Done, then Result1=12, Result2=0. Start pulses during COMPUTE ignored (Done count equals accepted starts).
- Reset driven low asynchronously mid-COMPUTE (counter=10) → Busy, Done, Result1, Result2 go to 0 without a clock edge. After release, no Done appears until a new Start is given.
